// File: rtl/cla_pkg.sv
// ============================================================================
// Module   : cla_pkg
// Purpose  : Shared constants, FSM state encoding and the group
//            propagate/generate combine helper for the multi-word CLA adder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cla_pkg;

  // Width of one lookahead slice handled per cycle.
  localparam int SLICE_W = 16;

  // Sequencer states.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } cla_state_e;

  // Combine a more-significant (hi) P/G pair with a less-significant (lo)
  // pair into the P/G of the concatenated group. Result packed as {P, G}.
  function automatic logic [1:0] pg_combine(input logic hi_p, input logic hi_g,
                                             input logic lo_p, input logic lo_g);
    return {hi_p & lo_p, hi_g | (hi_p & lo_g)};
  endfunction

endpackage

`default_nettype wire

// File: rtl/cla_multiword_seq_if.sv
// ============================================================================
// Module   : cla_multiword_seq_if
// Purpose  : Operand/result handshake bundle for the sequential multi-word
//            adder. The master issues operands and consumes results; the
//            slave is the adder itself.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cla_multiword_seq_if #(
  parameter int WORDS = 4
);
  localparam int W = cla_pkg::SLICE_W * WORDS;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         c_out;
  logic         ovf;
  logic         P;
  logic         G;

  modport master (
    output in_valid, a, b, c_in, out_ready,
    input  in_ready, out_valid, sum, c_out, ovf, P, G
  );

  modport slave (
    input  in_valid, a, b, c_in, out_ready,
    output in_ready, out_valid, sum, c_out, ovf, P, G
  );

endinterface

`default_nettype wire

// File: rtl/cla_multiword_seq_cla16.sv
// ============================================================================
// Module   : CLA_16_bit_LAC
// Purpose  : Purely combinational 16-bit carry-lookahead adder built from
//            four 4-bit groups and a second-level lookahead carry unit.
//            Exposes block propagate/generate for chaining wider adders.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module CLA_16_bit_LAC
  import cla_pkg::*;
(
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic        c_i,
  output logic [15:0] sum_o,
  output logic        c_o,
  output logic        p_o,
  output logic        g_o
);

  logic [15:0] w_p;
  logic [15:0] w_g;
  logic [15:0] w_carry;
  logic [3:0]  w_grp_p;
  logic [3:0]  w_grp_g;
  logic [4:0]  w_grp_c;

  assign w_p = a_i ^ b_i;
  assign w_g = a_i & b_i;

  // Per-group P/G as a two-level tree of bit-pair combines.
  for (genvar j = 0; j < 4; j++) begin : g_grp
    logic [1:0] w_lo;
    logic [1:0] w_hi;
    assign w_lo = pg_combine(w_p[4*j+1], w_g[4*j+1], w_p[4*j],   w_g[4*j]);
    assign w_hi = pg_combine(w_p[4*j+3], w_g[4*j+3], w_p[4*j+2], w_g[4*j+2]);
    assign {w_grp_p[j], w_grp_g[j]} = pg_combine(w_hi[1], w_hi[0], w_lo[1], w_lo[0]);
  end

  // Second-level lookahead: each group carry-in is a flat sum of products.
  assign w_grp_c[0] = c_i;
  assign w_grp_c[1] = w_grp_g[0] | (w_grp_p[0] & c_i);
  assign w_grp_c[2] = w_grp_g[1] | (w_grp_p[1] & w_grp_g[0])
                    | (w_grp_p[1] & w_grp_p[0] & c_i);
  assign w_grp_c[3] = w_grp_g[2] | (w_grp_p[2] & w_grp_g[1])
                    | (w_grp_p[2] & w_grp_p[1] & w_grp_g[0])
                    | (w_grp_p[2] & w_grp_p[1] & w_grp_p[0] & c_i);
  assign w_grp_c[4] = w_grp_g[3] | (w_grp_p[3] & w_grp_g[2])
                    | (w_grp_p[3] & w_grp_p[2] & w_grp_g[1])
                    | (w_grp_p[3] & w_grp_p[2] & w_grp_p[1] & w_grp_g[0])
                    | (w_grp_p[3] & w_grp_p[2] & w_grp_p[1] & w_grp_p[0] & c_i);

  // Bit carries inside a group come from that group's lookahead carry-in.
  for (genvar i = 0; i < 16; i++) begin : g_bit
    if ((i % 4) == 0) begin : g_grp_base
      assign w_carry[i] = w_grp_c[i/4];
    end else begin : g_grp_inner
      assign w_carry[i] = w_g[i-1] | (w_p[i-1] & w_carry[i-1]);
    end
  end

  assign sum_o = w_p ^ w_carry;
  assign c_o   = w_grp_c[4];
  assign p_o   = &w_grp_p;
  assign g_o   = w_grp_g[3] | (w_grp_p[3] & w_grp_g[2])
               | (w_grp_p[3] & w_grp_p[2] & w_grp_g[1])
               | (w_grp_p[3] & w_grp_p[2] & w_grp_p[1] & w_grp_g[0]);

endmodule

`default_nettype wire

// File: rtl/cla_multiword_seq.sv
// ============================================================================
// Module   : cla_multiword_seq
// Purpose  : Sequential WORDS x 16-bit adder. Latches wide operands, feeds
//            one slice per cycle through a 16-bit CLA core, chains the
//            carry and folds group P/G, then holds the result until taken.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cla_multiword_seq
  import cla_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  cla_multiword_seq_if.slave bus
);

  localparam int              W      = SLICE_W * WORDS;
  localparam int              KW     = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [KW-1:0]   K_LAST = KW'(WORDS - 1);

  localparam logic [1:0] ST_IDLE = S_IDLE;
  localparam logic [1:0] ST_RUN  = S_RUN;
  localparam logic [1:0] ST_DONE = S_DONE;

  logic [1:0]    state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic          carry_q, carry_d;
  logic          p_acc_q, p_acc_d;
  logic          g_acc_q, g_acc_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          c_out_q, c_out_d;
  logic          ovf_q, ovf_d;
  logic          p_q, p_d;
  logic          g_q, g_d;

  logic [SLICE_W-1:0] w_a_slice;
  logic [SLICE_W-1:0] w_b_slice;
  logic [SLICE_W-1:0] w_slice_sum;
  logic               w_slice_c;
  logic               w_slice_p;
  logic               w_slice_g;
  logic [1:0]         w_pg_acc;

  assign w_a_slice = a_q[k_q*SLICE_W +: SLICE_W];
  assign w_b_slice = b_q[k_q*SLICE_W +: SLICE_W];

  CLA_16_bit_LAC u_cla (
    .a_i   (w_a_slice),
    .b_i   (w_b_slice),
    .c_i   (carry_q),
    .sum_o (w_slice_sum),
    .c_o   (w_slice_c),
    .p_o   (w_slice_p),
    .g_o   (w_slice_g)
  );

  // Current slice is more significant than everything accumulated so far.
  assign w_pg_acc = pg_combine(w_slice_p, w_slice_g, p_acc_q, g_acc_q);

  // Next-state: accept in IDLE, one slice per RUN cycle, hold in DONE.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    p_acc_d = p_acc_q;
    g_acc_d = g_acc_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
    p_d     = p_q;
    g_d     = g_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.c_in;
          k_d     = '0;
          p_acc_d = 1'b1;
          g_acc_d = 1'b0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        sum_d[k_q*SLICE_W +: SLICE_W] = w_slice_sum;
        carry_d                       = w_slice_c;
        {p_acc_d, g_acc_d}            = w_pg_acc;
        if (k_q == K_LAST) begin
          c_out_d = w_slice_c;
          // Overflow when like-signed operands yield an opposite-signed sum.
          ovf_d   = (a_q[W-1] == b_q[W-1]) && (w_slice_sum[SLICE_W-1] != a_q[W-1]);
          p_d     = w_pg_acc[1];
          g_d     = w_pg_acc[0];
          state_d = ST_DONE;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything, dropping any
  // in-flight transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      p_acc_q <= 1'b0;
      g_acc_q <= 1'b0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
      p_q     <= 1'b0;
      g_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      p_acc_q <= p_acc_d;
      g_acc_q <= g_acc_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
      p_q     <= p_d;
      g_q     <= g_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.sum       = sum_q;
  assign bus.c_out     = c_out_q;
  assign bus.ovf       = ovf_q;
  assign bus.P         = p_q;
  assign bus.G         = g_q;

endmodule

`default_nettype wire

// File: tb/tb_cla_multiword_seq.sv
// ============================================================================
// Module   : tb_cla_multiword_seq
// Purpose  : Scoreboard bench for cla_multiword_seq (WORDS=4). Expected
//            results come from plain wide-integer arithmetic on the operands.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cla_multiword_seq;

  localparam int WORDS = 4;
  localparam int W     = 16 * WORDS;

  typedef struct {
    logic [W-1:0] sum;
    logic         c_out;
    logic         ovf;
    logic         p;
    logic         g;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   failures;
  exp_t exp_q[$];
  int   lat_q[$];

  cla_multiword_seq_if #(.WORDS(WORDS)) bus ();

  cla_multiword_seq #(.WORDS(WORDS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: full-width integer add; G is the carry out with no carry in,
  // P is "every bit position propagates".
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic ci);
    exp_t       e;
    logic [W:0] full;
    logic [W:0] gen;
    full    = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    gen     = {1'b0, a} + {1'b0, b};
    e.sum   = full[W-1:0];
    e.c_out = full[W];
    e.ovf   = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
    e.p     = &(a ^ b);
    e.g     = gen[W];
    return e;
  endfunction

  function automatic logic [W-1:0] rnd_op();
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < WORDS; i++) begin
      case ($urandom_range(0, 3))
        0:       v[16*i +: 16] = 16'hFFFF;
        1:       v[16*i +: 16] = 16'h0000;
        default: v[16*i +: 16] = 16'($urandom);
      endcase
    end
    return v;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Issue one transaction; called in the phase just after a rising edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                      input bit track, output int acc_cyc);
    int guard;
    guard = 0;
    while (bus.in_ready !== 1'b1 && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 200) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: in_ready stuck at %b required 1", bus.in_ready);
      acc_cyc = -1;
      return;
    end
    bus.a        = a;
    bus.b        = b;
    bus.c_in     = ci;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a        = {$urandom, $urandom};
    bus.b        = {$urandom, $urandom};
    bus.c_in     = 1'($urandom);
    acc_cyc      = cyc;
    if (track) begin
      exp_q.push_back(model(a, b, ci));
      lat_q.push_back(cyc + WORDS);
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 500) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: pending=%0d required 0", exp_q.size());
      exp_q.delete();
      lat_q.delete();
    end
  endtask

  // Monitor: latency on each out_valid rise, full result on each transfer.
  initial begin : monitor
    logic prev;
    exp_t e;
    int   lat;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.out_valid === 1'b1 && !prev) begin
        if (lat_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL latency: out_valid rose at cycle %0d with no accept pending", cyc);
        end else begin
          lat = lat_q.pop_front();
          chk("latency_cycle", W'(cyc), W'(lat));
        end
      end
      prev = (bus.out_valid === 1'b1);
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output: sum=%0h with no transaction pending", bus.sum);
        end else begin
          e = exp_q.pop_front();
          chk("sum",   bus.sum,   e.sum);
          chk("c_out", W'(bus.c_out), W'(e.c_out));
          chk("ovf",   W'(bus.ovf),   W'(e.ovf));
          chk("P",     W'(bus.P),     W'(e.p));
          chk("G",     W'(bus.G),     W'(e.g));
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int   t0;
    int   t1;
    int   t2;
    int   guard;
    exp_t e;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    checks        = 0;
    failures      = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.a         = '0;
    bus.b         = '0;
    bus.c_in      = 1'b0;

    #12;
    chk("rst_in_ready",  W'(bus.in_ready),  W'(1));
    chk("rst_out_valid", W'(bus.out_valid), W'(0));
    chk("rst_sum",       bus.sum,           '0);
    chk("rst_flags",     W'({bus.c_out, bus.ovf, bus.P, bus.G}), W'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Carry ripple, signed overflow, propagate-only with both carry-ins.
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b1, t0);
    send(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b1, t0);
    send(64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0, 1'b1, t0);
    send(64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA, 1'b1, 1'b1, t0);
    drain();

    // Backpressure: result must hold and a stray in_valid must be ignored.
    bus.out_ready = 1'b0;
    ra = 64'h8000_1234_FFFF_0001;
    rb = 64'h8000_4321_0001_FFFF;
    e  = model(ra, rb, 1'b1);
    send(ra, rb, 1'b1, 1'b1, t0);
    guard = 0;
    while (bus.out_valid !== 1'b1 && guard < 20) begin
      @(posedge clk);
      #1;
      guard++;
    end
    chk("bp_out_valid", W'(bus.out_valid), W'(1));
    for (int i = 0; i < 6; i++) begin
      chk("bp_hold_sum", bus.sum, e.sum);
      chk("bp_hold_flags", W'({bus.c_out, bus.ovf, bus.P, bus.G}),
          W'({e.c_out, e.ovf, e.p, e.g}));
      chk("bp_in_ready", W'(bus.in_ready), W'(0));
      if (i == 2) begin
        bus.a        = 64'h0123_4567_89AB_CDEF;
        bus.b        = 64'h1111_1111_1111_1111;
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_in_ready", W'(bus.in_ready), W'(1));
    drain();

    // Back-to-back with out_ready held high.
    send(64'hFFFF, 64'h0, 1'b1, 1'b1, t1);
    send(64'h3, 64'h5, 1'b0, 1'b1, t2);
    chk("b2b_interval", W'(t2 - t1), W'(WORDS + 2));
    drain();

    // Reset in the middle of RUN, after two slices have been processed.
    send(64'h1234_5678_9ABC_DEF0, 64'h1111_2222_3333_4444, 1'b1, 1'b0, t0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready",  W'(bus.in_ready),  W'(1));
    chk("midrst_out_valid", W'(bus.out_valid), W'(0));
    chk("midrst_sum",       bus.sum,           '0);
    chk("midrst_flags",     W'({bus.c_out, bus.ovf, bus.P, bus.G}), W'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(64'h1, 64'h1, 1'b0, 1'b1, t0);
    drain();

    // Randomised transactions with slice-boundary-heavy operands.
    for (int n = 0; n < 24; n++) begin
      ra = rnd_op();
      rb = rnd_op();
      send(ra, rb, 1'($urandom), 1'b1, t0);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
    end
    drain();

    repeat (4) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cla_multiword_seq.md
# cla_multiword_seq

Sequential multi-word adder that drives the 16-bit carry-lookahead core (`CLA_16_bit_LAC`) one 16-bit slice per cycle. It adds operands of `16*WORDS` bits, chaining carry between slices, and accumulates group propagate/generate across the full width. It sits directly upstream of the 16-bit CLA, accepting wide operands through a valid/ready handshake and presenting a registered wide result downstream.

## Interface
- `WORDS`, default 4: number of 16-bit slices; operand width `W = 16*WORDS`; legal range 1..16.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `in_valid`  in  1  operands and `c_in` valid.
- `in_ready`  out  1  block idle and able to accept.
- `a`  in  W  operand A, unsigned/two's complement.
- `b`  in  W  operand B.
- `c_in`  in  1  carry into slice 0.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts result.
- `sum`  out  W  A+B+c_in mod 2^W.
- `c_out`  out  1  carry out of slice WORDS-1.
- `ovf`  out  1  signed overflow: MSB of A equals MSB of B and differs from MSB of `sum`.
- `P`, `G`  out  1 each  group propagate and generate over all W bits.

## Operation
- FSM states:
  - IDLE: `in_ready`=1. When `in_valid`, latch `a`, `b` and `c_in` into operand registers, clear slice index `k`, set `P_acc`=1 and `G_acc`=0, then go to RUN.
  - RUN: the CLA core receives slice k of the latched operands plus the carry register.
    - Slice sum goes to `sum[16k+15:16k]`; the carry register takes the core's `c_out`.
    - Accumulator updates: `P_acc <= P_acc & P_k` and `G_acc <= G_k | (P_k & G_acc)`.
    - When k == WORDS-1, register `c_out` and compute `ovf` from the latched MSBs and the final sum MSB. Then go to DONE; otherwise increment k.
  - DONE: `out_valid`=1. When `out_ready`, go to IDLE.
- `in_valid` is ignored outside IDLE, and `a`, `b`, `c_in` may change freely after acceptance.
- `sum`, `c_out`, `ovf`, `P` and `G` are held stable from entry to DONE until the next transaction reaches its first RUN cycle. They are only meaningful while `out_valid`=1.
- `k` width is clog2(WORDS), minimum 1. For WORDS=1 the FSM goes IDLE→RUN→DONE with a single RUN cycle.
- All arithmetic is modulo 2^W. There is no saturation.

## Timing
- Reset values while `rst`=0: state IDLE, `in_ready`=1, `out_valid`=0, `sum`=0, `c_out`=0, `ovf`=0, `P`=0, `G`=0, `k`=0, carry register=0, operand registers=0.
- Reset takes effect immediately and asynchronously, including mid-RUN. An in-flight transaction is dropped with no partial output.
- Acceptance happens on edge E0 when `in_valid`&`in_ready`=1. RUN occupies the cycles after edges E0..E(WORDS-1). `out_valid` rises after edge E(WORDS), so latency is WORDS cycles.
- Output transfer happens on the edge with `out_valid`&`out_ready`=1. `in_ready` rises the following cycle, so the minimum initiation interval is WORDS+2 cycles.
- `in_ready` and `out_valid` are decoded from registered state only. There is no combinational path from `in_valid` or `out_ready` to any output.

## Structure
- Shared package `cla_pkg`:
  - slice width constant `SLICE_W = 16`;
  - FSM state enum {IDLE, RUN, DONE};
  - helper function for the group P/G combine step.
- One sub-module instance: `CLA_16_bit_LAC`, used combinationally on slice k. The FSM, index counter, operand registers, carry register and result registers live in `cla_multiword_seq`.

## Test plan
All scenarios use WORDS=4 (W=64).
- **Carry ripple:** a=64'hFFFF_FFFF_FFFF_FFFF, b=1, c_in=0 → sum=0, c_out=1, ovf=0, P=0, G=1. `out_valid` is high exactly 4 cycles after accept.
- **Signed overflow:** a=64'h7FFF_FFFF_FFFF_FFFF, b=1, c_in=0 → sum=64'h8000_0000_0000_0000, c_out=0, ovf=1.
- **Propagate only:** a=64'h5555_5555_5555_5555, b=64'hAAAA_AAAA_AAAA_AAAA, c_in=0 → sum=all ones, P=1, G=0, c_out=0. Repeating with c_in=1 gives sum=0, c_out=1.
- **Backpressure:**
  - Hold `out_ready`=0 for 6 cycles in DONE → `sum`, `c_out`, `ovf`, `P`, `G` stay stable and `in_ready`=0.
  - A second `in_valid` pulse in this window is ignored.
  - Raising `out_ready` → `in_ready`=1 the next cycle.
- **Back-to-back, out_ready tied 1:** txn1 a=64'hFFFF, b=0, c_in=1 → sum=64'h1_0000; txn2 a=3, b=5, c_in=0 → sum=8. The second accept occurs exactly WORDS+2 cycles after the first.
- **Reset mid-RUN:** drop `rst` to 0 after 2 slices are processed → all outputs are immediately 0 and `in_ready`=1. After release, a fresh transaction a=1, b=1 → sum=2 with no residue from the aborted one.
